// File: rtl/input_cond_pkg.sv
// input_cond_pkg: shared switch width, default timing constants and button FSM states
package input_cond_pkg;
  localparam int SW_W = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_CYCLES = 25000000;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} btn_state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser bank for asynchronous inputs
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;
  // back-to-back flops with nothing in between so the first stage can settle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  assign q = r_sync;
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: sync + debounce of switches and confirm button; INPUT_COND_REPEAT_EN adds held-button auto-repeat
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W = 20,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SW_W-1:0] sw_raw,
  input  logic            btn_raw,
  output logic [SW_W-1:0] sw_stable,
  output logic            btn_level,
  output logic            btn_pulse,
  output logic [SW_W-1:0] sw_captured
);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  if (DEBOUNCE_CYCLES < 2 || (64'(1) << CNT_W) <= 64'(DEBOUNCE_CYCLES) || REPEAT_CYCLES < 2) begin : g_bad_cfg
    $error("input_conditioner: illegal DEBOUNCE_CYCLES/CNT_W/REPEAT_CYCLES");
  end
  logic [SW_W:0]      w_sync;
  logic [SW_W-1:0]    w_sw;
  logic               w_btn;
  logic [SW_W-1:0]    r_sw_stable;
  logic [SW_W-1:0]    r_sw_last;
  logic [CNT_W-1:0]   r_sw_cnt;
  btn_state_t         r_state;
  btn_state_t         w_state_nxt;
  logic [CNT_W-1:0]   r_btn_cnt;
  logic [CNT_W-1:0]   w_btn_cnt_nxt;
  logic               w_press;
  logic               w_release;
  logic               w_repeat;
  logic               r_btn_level;
  logic               r_btn_pulse;
  logic [SW_W-1:0]    r_sw_captured;
  sync_2ff #(.WIDTH(SW_W + 1)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    ({btn_raw, sw_raw}),
    .q    (w_sync)
  );
  assign w_sw  = w_sync[SW_W-1:0];
  assign w_btn = w_sync[SW_W];
  // a new vector must hold for DEBOUNCE_CYCLES cycles; a change restarts the count with this cycle as the first
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sw_stable <= '0;
      r_sw_last   <= '0;
      r_sw_cnt    <= '0;
    end else begin
      r_sw_last <= w_sw;
      if (w_sw == r_sw_stable) r_sw_cnt <= '0;
      else if (w_sw != r_sw_last) r_sw_cnt <= CNT_W'(1);
      else if (r_sw_cnt == DB_LAST) begin
        r_sw_stable <= w_sw;
        r_sw_cnt    <= '0;
      end else r_sw_cnt <= r_sw_cnt + CNT_W'(1);
    end
  // button FSM next state; the cycle a wait state is entered counts as its first debounce cycle
  always_comb begin
    w_state_nxt   = r_state;
    w_btn_cnt_nxt = '0;
    w_press       = 1'b0;
    w_release     = 1'b0;
    case (r_state)
      IDLE:
        if (w_btn) begin
          w_state_nxt   = PRESS_WAIT;
          w_btn_cnt_nxt = CNT_W'(1);
        end
      PRESS_WAIT:
        if (!w_btn) w_state_nxt = IDLE;
        else if (r_btn_cnt == DB_LAST) begin
          w_state_nxt = HELD;
          w_press     = 1'b1;
        end else w_btn_cnt_nxt = r_btn_cnt + CNT_W'(1);
      HELD:
        if (!w_btn) begin
          w_state_nxt   = RELEASE_WAIT;
          w_btn_cnt_nxt = CNT_W'(1);
        end
      RELEASE_WAIT:
        if (w_btn) w_state_nxt = HELD;
        else if (r_btn_cnt == DB_LAST) begin
          w_state_nxt = IDLE;
          w_release   = 1'b1;
        end else w_btn_cnt_nxt = r_btn_cnt + CNT_W'(1);
      default: w_state_nxt = IDLE;
    endcase
  end
`ifdef INPUT_COND_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] r_rpt_cnt;
  logic             w_stay_held;
  assign w_stay_held = (r_state == HELD) && (w_state_nxt == HELD);
  assign w_repeat    = w_stay_held && (r_rpt_cnt == RPT_LAST);
  // repeat timer runs only while the button remains in HELD and restarts after each repeat
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rpt_cnt <= '0;
    else r_rpt_cnt <= (w_stay_held && !w_repeat) ? r_rpt_cnt + RPT_W'(1) : '0;
`else
  assign w_repeat = 1'b0;
`endif
  // FSM state, debounce counter and registered outputs; capture sees sw_stable from before this edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state       <= IDLE;
      r_btn_cnt     <= '0;
      r_btn_level   <= 1'b0;
      r_btn_pulse   <= 1'b0;
      r_sw_captured <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_btn_cnt     <= w_btn_cnt_nxt;
      r_btn_level   <= w_press ? 1'b1 : w_release ? 1'b0 : r_btn_level;
      r_btn_pulse   <= w_press | w_repeat;
      r_sw_captured <= (w_press | w_repeat) ? r_sw_stable : r_sw_captured;
    end
  assign sw_stable   = r_sw_stable;
  assign btn_level   = r_btn_level;
  assign btn_pulse   = r_btn_pulse;
  assign sw_captured = r_sw_captured;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: scoreboard bench with directed vectors, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8
module tb_input_conditioner;
  localparam int DB = 4;
  localparam int RP = 8;
  localparam int LAT = 2 + DB;
  typedef struct {
    int         cyc;
    logic [3:0] val;
  } ev_t;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw_raw = 4'h0;
  logic       btn_raw = 1'b0;
  logic [3:0] sw_stable;
  logic       btn_level;
  logic       btn_pulse;
  logic [3:0] sw_captured;
  ev_t        q_sw[$];
  ev_t        q_pulse[$];
  ev_t        q_lvl[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] prev_sw = 4'h0;
  logic       prev_lvl = 1'b0;

  input_conditioner #(.DEBOUNCE_CYCLES(DB), .CNT_W(4), .REPEAT_CYCLES(RP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_raw     (sw_raw),
    .btn_raw    (btn_raw),
    .sw_stable  (sw_stable),
    .btn_level  (btn_level),
    .btn_pulse  (btn_pulse),
    .sw_captured(sw_captured)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input int dc, input logic [3:0] v);
    ev_t e;
    e.cyc = cyc + dc;
    e.val = v;
    if (kind == 0) q_sw.push_back(e);
    else if (kind == 1) q_pulse.push_back(e);
    else q_lvl.push_back(e);
  endtask

  task automatic take(input int kind, input logic [3:0] v);
    ev_t   e;
    logic  have;
    string nm;
    have = 1'b0;
    nm = kind == 0 ? "sw_stable" : kind == 1 ? "btn_pulse" : "btn_level";
    if (kind == 0 && q_sw.size() != 0) begin e = q_sw.pop_front(); have = 1'b1; end
    if (kind == 1 && q_pulse.size() != 0) begin e = q_pulse.pop_front(); have = 1'b1; end
    if (kind == 2 && q_lvl.size() != 0) begin e = q_lvl.pop_front(); have = 1'b1; end
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL %s: unexpected event at cycle %0d value %0h, none expected", nm, cyc, v);
    end else if (e.cyc != cyc || e.val !== v) begin
      errors++;
      $display("FAIL %s: got cycle %0d value %0h, expected cycle %0d value %0h", nm, cyc, v, e.cyc, e.val);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      prev_sw  = sw_stable;
      prev_lvl = btn_level;
    end else begin
      if (sw_stable !== prev_sw) begin
        take(0, sw_stable);
        prev_sw = sw_stable;
      end
      if (btn_pulse) take(1, sw_captured);
      if (btn_level !== prev_lvl) begin
        take(2, {3'b000, btn_level});
        prev_lvl = btn_level;
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    #2;
    rst_n   = 1'b0;
    sw_raw  = 4'hF;
    btn_raw = 1'b1;
    step(3);
    chk("rst_sw_stable", sw_stable, 4'h0);
    chk("rst_btn_level", {3'b000, btn_level}, 4'h0);
    chk("rst_btn_pulse", {3'b000, btn_pulse}, 4'h0);
    chk("rst_sw_captured", sw_captured, 4'h0);
    rst_n = 1'b1;
    expect_ev(0, LAT, 4'hF);
    expect_ev(1, LAT, 4'h0);
    expect_ev(2, LAT, 4'h1);
    step(8);
    btn_raw = 1'b0;
    expect_ev(2, LAT, 4'h0);
    step(12);
    sw_raw = 4'h0;
    expect_ev(0, LAT, 4'h0);
    step(12);
    sw_raw = 4'hA;
    expect_ev(0, LAT, 4'hA);
    step(12);
    for (int i = 0; i < 10; i++) begin
      sw_raw[0] = ~sw_raw[0];
      step(2);
    end
    sw_raw = 4'hB;
    expect_ev(0, LAT, 4'hB);
    step(12);
    sw_raw = 4'h5;
    expect_ev(0, LAT, 4'h5);
    step(12);
    btn_raw = 1'b1;
    expect_ev(1, LAT, 4'h5);
    expect_ev(2, LAT, 4'h1);
    step(10);
    btn_raw = 1'b0;
    expect_ev(2, LAT, 4'h0);
    step(12);
    chk("capture_hold", sw_captured, 4'h5);
    btn_raw = 1'b1;
    step(3);
    btn_raw = 1'b0;
    step(12);
    chk("glitch_level", {3'b000, btn_level}, 4'h0);
    btn_raw = 1'b1;
    step(3);
    rst_n = 1'b0;
    step(2);
    chk("midrst_sw_stable", sw_stable, 4'h0);
    chk("midrst_btn_level", {3'b000, btn_level}, 4'h0);
    chk("midrst_btn_pulse", {3'b000, btn_pulse}, 4'h0);
    chk("midrst_sw_captured", sw_captured, 4'h0);
    rst_n = 1'b1;
    expect_ev(0, LAT, 4'h5);
    expect_ev(1, LAT, 4'h0);
    expect_ev(2, LAT, 4'h1);
`ifdef INPUT_COND_REPEAT_EN
    expect_ev(1, LAT + RP, 4'h5);
    expect_ev(1, LAT + 2 * RP, 4'h5);
    expect_ev(1, LAT + 3 * RP, 4'h5);
`endif
    step(30);
    btn_raw = 1'b0;
    expect_ev(2, LAT, 4'h0);
    step(12);
    chk("left_sw_events", 4'(q_sw.size()), 4'h0);
    chk("left_pulse_events", 4'(q_pulse.size()), 4'h0);
    chk("left_level_events", 4'(q_lvl.size()), 4'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
